// File: rtl/mux_pkg.sv
// Shared types and defaults for the N:1 registered multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    localparam int unsigned DefaultN = 16;
    localparam int unsigned DefaultW = 32;

    // Index width that stays at least one bit wide.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: the first requester after last_grant wins, with wrap.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned N  = DefaultN,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_grant,
    output logic          gnt_valid,
    output logic [SW-1:0] gnt_idx
);

    int unsigned first;

    // Candidate at distance k from the search start, folded back into 0..N-1.
    function automatic int unsigned slot(input int unsigned base, input int unsigned k);
        int unsigned s;
        s = base + k;
        if (s >= N) begin
            s = s - N;
        end
        return s;
    endfunction

    always_comb begin
        first = (32'(last_grant) >= N - 1) ? 32'd0 : 32'(last_grant) + 32'd1;
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!gnt_valid && req[slot(first, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(slot(first, k));
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 registered multiplexer with per-channel handshakes, fixed-select or round-robin
// arbitration, and a single-entry output register that sustains one item per cycle.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned N  = DefaultN,
    parameter  int unsigned W  = DefaultW,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din [N],
    input  logic [N-1:0]  din_valid,
    output logic [N-1:0]  din_ready,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    input  logic [N-1:0]  en_mask,
    output logic [W-1:0]  dout,
    output logic [SW-1:0] dout_ch,
    output logic          dout_valid,
    input  logic          dout_ready
);

    mux_mode_e     mode_e;
    logic          load;

    logic          fix_valid;
    logic          rr_valid;
    logic [SW-1:0] rr_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;

    logic [W-1:0]  dout_d, dout_q;
    logic [SW-1:0] dout_ch_d, dout_ch_q;
    logic          dout_valid_d, dout_valid_q;
    logic [SW-1:0] last_grant_d, last_grant_q;

    assign mode_e = mux_mode_e'(mode);
    assign load   = !dout_valid_q || dout_ready;

    // Guard the select before indexing so an out-of-range sel never reads past din_valid.
    always_comb begin
        fix_valid = 1'b0;
        if (32'(sel) < N) begin
            fix_valid = din_valid[sel];
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req        (din_valid & en_mask),
        .last_grant (last_grant_q),
        .gnt_valid  (rr_valid),
        .gnt_idx    (rr_idx)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        unique case (mode_e)
            MODE_FIXED: begin
                grant_valid = fix_valid;
                grant_idx   = sel;
            end
            MODE_RR: begin
                grant_valid = rr_valid;
                grant_idx   = rr_idx;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = '0;
            end
        endcase
    end

    // Held low during reset so producers see no accept while the output is being cleared.
    always_comb begin
        din_ready = '0;
        if (!rst && load && grant_valid) begin
            din_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (grant_valid) begin
                dout_d       = din[grant_idx];
                dout_ch_d    = grant_idx;
                dout_valid_d = 1'b1;
                if (mode_e == MODE_RR) begin
                    last_grant_d = grant_idx;
                end
            end else begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            last_grant_q <= SW'(N - 1);
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr with a scoreboard of expected output items.
module tb_mux_nx1_rr;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 32;
    localparam int unsigned SW = 4;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } item_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  din [N];
    logic [N-1:0]  din_valid;
    logic [N-1:0]  din_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  en_mask;
    logic [W-1:0]  dout;
    logic [SW-1:0] dout_ch;
    logic          dout_valid;
    logic          dout_ready;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    mux_nx1_rr #(
        .N (N),
        .W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .sel        (sel),
        .en_mask    (en_mask),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
    task automatic cycle(input string tag, input int exp_ch, input logic [N-1:0] exp_rdy);
        item_t it;
        #1;
        check({tag, " din_ready"}, 64'(din_ready), 64'(exp_rdy));
        if (exp_ch >= 0) begin
            it.ch   = exp_ch;
            it.data = 32'hA + 32'(exp_ch);
            q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted output item must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                check("unexpected output", 64'(dout_ch), 64'hFFFF);
            end else begin
                item_t it;
                it = q.pop_front();
                check("out ch", 64'(dout_ch), 64'(it.ch));
                check("out data", 64'(dout), 64'(it.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] one;
        one = 16'h0001;
        rst        = 1'b1;
        mode       = 1'b0;
        sel        = 4'd5;
        en_mask    = 16'hFFFF;
        din_valid  = 16'hFFFF;
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) din[i] = 32'hA + 32'(i);

        #2;
        check("reset dout_valid", 64'(dout_valid), 64'd0);
        check("reset dout", 64'(dout), 64'd0);
        check("reset din_ready", 64'(din_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed select on channel 5.
        for (int i = 0; i < 4; i++) cycle("fixed", 5, one << 5);

        // Full round robin: 0..15 then wrap to 0.
        mode = 1'b1;
        for (int i = 0; i < 17; i++) cycle("rr", i % 16, one << (i % 16));

        // Masked round robin continues after the last grant (ch0).
        en_mask = 16'h8101;
        cycle("mask", 8, one << 8);
        cycle("mask", 15, one << 15);
        cycle("mask", 0, one << 0);
        cycle("mask", 8, one << 8);
        cycle("mask", 15, one << 15);

        // Backpressure: ch15 item held, no accepts.
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp", -1, '0);
            check("bp dout", 64'(dout), 64'h19);
            check("bp dout_ch", 64'(dout_ch), 64'd15);
            check("bp dout_valid", 64'(dout_valid), 64'd1);
        end
        dout_ready = 1'b1;
        cycle("bp release", 0, one << 0);
        cycle("bp release", 8, one << 8);

        // Leave last RR grant at 3, detour through FIXED, then resume RR.
        en_mask = 16'h0008;
        cycle("to3", 3, one << 3);
        mode = 1'b0;
        sel  = 4'd10;
        cycle("fixed10", 10, one << 10);
        cycle("fixed10", 10, one << 10);
        mode    = 1'b1;
        en_mask = 16'hFFFF;
        cycle("resume", 4, one << 4);
        cycle("resume", 5, one << 5);

        // Empty mask: nothing granted, output drains after one cycle.
        en_mask = 16'h0000;
        cycle("mask0", -1, '0);
        check("drain dout_valid", 64'(dout_valid), 64'd0);
        check("drain dout hold", 64'(dout), 64'hF);
        check("drain dout_ch hold", 64'(dout_ch), 64'd5);

        // Reset mid-cycle while an item (ch6) is on the output; it is discarded.
        en_mask = 16'hFFFF;
        #1;
        check("pre-rst din_ready", 64'(din_ready), 64'(one << 6));
        @(posedge clk);
        #2;
        check("pre-rst dout_valid", 64'(dout_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid-rst dout_valid", 64'(dout_valid), 64'd0);
        check("mid-rst dout", 64'(dout), 64'd0);
        check("mid-rst dout_ch", 64'(dout_ch), 64'd0);
        check("mid-rst din_ready", 64'(din_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post-rst", 0, one << 0);

        // Idle: all invalid, output drops after one cycle.
        din_valid = '0;
        cycle("idle", -1, '0);
        check("idle dout_valid", 64'(dout_valid), 64'd0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("scoreboard empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
